// File: rtl/minibyte_control.sv
// ---------------------------------------------------------------------------
// minibyte_control
//
// Instruction sequencer for the minibyte CPU. Each instruction is two bytes
// (opcode, operand) read from memory at PC. The sequencer walks through
// FETCH_OP -> FETCH_ARG [-> EXEC] and drives the register strobes, the
// address mux, the ALU operation and the memory write strobe. It also keeps
// registered copies of the ALU Z/N flags that the branches test.
//
// Parameters
//   HALT_EN        1: opcode 0xF halts the CPU, 0: opcode 0xF acts as NOP
//
// Ports
//   clk_in         in   1  clock, all state changes on the rising edge
//   rst_in         in   1  synchronous active-high reset
//   data_in        in   8  memory read data (opcode or operand byte)
//   flag_z_in      in   1  ALU zero flag for the current ALU result
//   flag_n_in      in   1  ALU negative flag for the current ALU result
//   ctrl_set_a     out  1  load A from the ALU result
//   ctrl_set_m     out  1  load M from the ALU result
//   ctrl_set_pc    out  1  load PC from the ALU result
//   ctrl_inc_pc    out  1  increment PC
//   ctrl_addr_mux  out  1  memory address select: 0 = PC, 1 = M
//   ctrl_alu_op    out  3  ALU operation (PASSB/ADD/SUB/AND/OR/XOR)
//   we_out         out  1  memory write strobe (address M, data A)
//   halted_out     out  1  sequencer is halted
// ---------------------------------------------------------------------------
module minibyte_control #(
    parameter bit HALT_EN = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_in,
    input  logic       flag_z_in,
    input  logic       flag_n_in,
    output logic       ctrl_set_a,
    output logic       ctrl_set_m,
    output logic       ctrl_set_pc,
    output logic       ctrl_inc_pc,
    output logic       ctrl_addr_mux,
    output logic [2:0] ctrl_alu_op,
    output logic       we_out,
    output logic       halted_out
);

    // Sequencer states
    typedef enum logic [1:0] {
        ST_FETCH_OP  = 2'd0,
        ST_FETCH_ARG = 2'd1,
        ST_EXEC      = 2'd2,
        ST_HALT      = 2'd3
    } state_t;

    // Opcode field values (upper nibble of the opcode byte)
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_STA = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_BZ  = 4'h9;
    localparam logic [3:0] OP_BN  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ALU operation codes
    localparam logic [2:0] ALU_PASSB = 3'b000;

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic       flag_z_q, flag_z_d;
    logic       flag_n_q, flag_n_d;

    // Decoded fields of the latched opcode
    logic [3:0] ir_op;
    logic       ir_direct;
    logic       ir_is_alu;
    logic       ir_is_sta;
    logic [2:0] ir_alu_code;
    logic       branch_taken;

    // The low three opcode bits carry no meaning, and the operand byte is
    // consumed by the datapath rather than by the sequencer.
    logic unused_bits;
    assign unused_bits = ^{ir_q[2:0], data_in[2:0]};

    // Opcode decode. LDA..XOR are numbered 1..6 and their ALU codes are
    // simply op - 1, which puts LDA on PASSB.
    always_comb begin
        ir_op       = ir_q[7:4];
        ir_direct   = ir_q[3];
        ir_is_alu   = (ir_op >= OP_LDA) && (ir_op <= OP_XOR);
        ir_is_sta   = (ir_op == OP_STA);
        ir_alu_code = 3'(ir_op - 4'd1);
        branch_taken = 1'b0;
        if (ir_op == OP_BZ) begin
            branch_taken = flag_z_q;
        end else if (ir_op == OP_BN) begin
            branch_taken = flag_n_q;
        end
    end

    // Next-state and output decode. Outputs depend on the state, the
    // latched opcode, the registered flags and, in FETCH_OP, the incoming
    // opcode byte. Everything is held at zero while reset is asserted.
    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        flag_z_d      = flag_z_q;
        flag_n_d      = flag_n_q;
        ctrl_set_a    = 1'b0;
        ctrl_set_m    = 1'b0;
        ctrl_set_pc   = 1'b0;
        ctrl_inc_pc   = 1'b0;
        ctrl_addr_mux = 1'b0;
        ctrl_alu_op   = ALU_PASSB;
        we_out        = 1'b0;
        halted_out    = 1'b0;

        if (!rst_in) begin
            case (state_q)
                ST_FETCH_OP: begin
                    ctrl_inc_pc = 1'b1;
                    ir_d        = data_in;
                    if (HALT_EN && (data_in[7:4] == OP_HLT)) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH_ARG;
                    end
                end

                ST_FETCH_ARG: begin
                    state_d = ST_FETCH_OP;
                    if (ir_is_alu && !ir_direct) begin
                        // Immediate: the operand byte goes straight to the ALU
                        ctrl_alu_op = ir_alu_code;
                        ctrl_set_a  = 1'b1;
                        ctrl_inc_pc = 1'b1;
                    end else if ((ir_is_alu || ir_is_sta) && ir_direct) begin
                        // Direct: the operand is an address, park it in M
                        ctrl_set_m  = 1'b1;
                        ctrl_inc_pc = 1'b1;
                        state_d     = ST_EXEC;
                    end else if (ir_op == OP_JMP) begin
                        ctrl_set_pc = 1'b1;
                    end else if ((ir_op == OP_BZ) || (ir_op == OP_BN)) begin
                        // PC either takes the operand or steps past it
                        ctrl_set_pc = branch_taken;
                        ctrl_inc_pc = !branch_taken;
                    end else begin
                        // NOP, reserved ops, STA immediate, HLT when disabled
                        ctrl_inc_pc = 1'b1;
                    end
                end

                ST_EXEC: begin
                    ctrl_addr_mux = 1'b1;
                    state_d       = ST_FETCH_OP;
                    if (ir_is_alu) begin
                        ctrl_alu_op = ir_alu_code;
                        ctrl_set_a  = 1'b1;
                    end else if (ir_is_sta) begin
                        we_out = 1'b1;
                    end
                end

                ST_HALT: begin
                    halted_out = 1'b1;
                end

                default: begin
                    state_d = ST_FETCH_OP;
                end
            endcase

            // Flags track the ALU result only when it lands in A
            if (ctrl_set_a) begin
                flag_z_d = flag_z_in;
                flag_n_d = flag_n_in;
            end
        end
    end

    // State, instruction and flag registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_FETCH_OP;
            ir_q     <= 8'h00;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
        end
    end

    // OP_NOP documents the encoding of the default-path opcode
    logic unused_nop;
    assign unused_nop = ^OP_NOP;

endmodule

// File: tb/tb_minibyte_control.sv
// ---------------------------------------------------------------------------
// tb_minibyte_control
//
// Drives whole instructions into two sequencer instances (HALT_EN = 1 and
// HALT_EN = 0) and compares every cycle's control outputs with an
// instruction-level reference model that tracks only the Z/N flags.
// ---------------------------------------------------------------------------
module tb_minibyte_control;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [7:0] data_in;
    logic       flag_z_in;
    logic       flag_n_in;

    logic       set_a0, set_m0, set_pc0, inc_pc0, addr_mux0, we0, halted0;
    logic [2:0] alu_op0;
    logic       set_a1, set_m1, set_pc1, inc_pc1, addr_mux1, we1, halted1;
    logic [2:0] alu_op1;

    int checks = 0;
    int errors = 0;

    // Reference model state: the registered flags
    bit model_z;
    bit model_n;

    always #5 clk_in = ~clk_in;

    minibyte_control #(.HALT_EN(1'b1)) u_dut_halt (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .data_in       (data_in),
        .flag_z_in     (flag_z_in),
        .flag_n_in     (flag_n_in),
        .ctrl_set_a    (set_a0),
        .ctrl_set_m    (set_m0),
        .ctrl_set_pc   (set_pc0),
        .ctrl_inc_pc   (inc_pc0),
        .ctrl_addr_mux (addr_mux0),
        .ctrl_alu_op   (alu_op0),
        .we_out        (we0),
        .halted_out    (halted0)
    );

    minibyte_control #(.HALT_EN(1'b0)) u_dut_nohalt (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .data_in       (data_in),
        .flag_z_in     (flag_z_in),
        .flag_n_in     (flag_n_in),
        .ctrl_set_a    (set_a1),
        .ctrl_set_m    (set_m1),
        .ctrl_set_pc   (set_pc1),
        .ctrl_inc_pc   (inc_pc1),
        .ctrl_addr_mux (addr_mux1),
        .ctrl_alu_op   (alu_op1),
        .we_out        (we1),
        .halted_out    (halted1)
    );

    // Output vector layout: {set_a, set_m, set_pc, inc_pc, addr_mux, alu_op, we, halted}
    function automatic logic [9:0] expVec(input bit sa, input bit sm, input bit sp,
                                          input bit ip, input bit am,
                                          input logic [2:0] alu, input bit we,
                                          input bit h);
        return {sa, sm, sp, ip, am, alu, we, h};
    endfunction

    function automatic logic [9:0] obsVec(input int which);
        if (which == 0) begin
            return {set_a0, set_m0, set_pc0, inc_pc0, addr_mux0, alu_op0, we0, halted0};
        end
        return {set_a1, set_m1, set_pc1, inc_pc1, addr_mux1, alu_op1, we1, halted1};
    endfunction

    task automatic checkOutput(input string tag, input int which, input logic [9:0] exp);
        logic [9:0] obs;
        obs = obsVec(which);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s dut%0d: observed %b expected %b", tag, which, obs, exp);
        end
    endtask

    // Drive inputs mid-cycle (just after the falling edge) and let them settle
    task automatic applyStimulus(input logic [7:0] d, input logic fz, input logic fn);
        data_in   = d;
        flag_z_in = fz;
        flag_n_in = fn;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // Run one complete instruction (never opcode F) through both instances.
    // fz/fn are the ALU flags presented during the operand and execute cycles.
    task automatic executeInstr(input string tag, input logic [7:0] opc,
                                input logic [7:0] arg, input logic fz, input logic fn);
        logic [3:0] op;
        bit         mode;
        bit         is_alu;
        bit         taken;
        bit         exec;
        bit         upd;
        logic [2:0] alu;
        logic [9:0] exp;

        op     = opc[7:4];
        mode   = opc[3];
        is_alu = (op >= 4'd1) && (op <= 4'd6);
        alu    = 3'(op - 4'd1);
        exec   = 0;
        upd    = 0;

        // Opcode fetch: always PC-addressed with PC increment
        applyStimulus(opc, 1'($urandom), 1'($urandom));
        exp = expVec(0, 0, 0, 1, 0, 3'b000, 0, 0);
        checkOutput({tag, "_fetch"}, 0, exp);
        checkOutput({tag, "_fetch"}, 1, exp);
        nextCycle();

        // Operand cycle
        applyStimulus(arg, fz, fn);
        if (is_alu && !mode) begin
            exp = expVec(1, 0, 0, 1, 0, alu, 0, 0);
            upd = 1;
        end else if ((is_alu || op == 4'd7) && mode) begin
            exp  = expVec(0, 1, 0, 1, 0, 3'b000, 0, 0);
            exec = 1;
        end else if (op == 4'd8) begin
            exp = expVec(0, 0, 1, 0, 0, 3'b000, 0, 0);
        end else if (op == 4'd9 || op == 4'd10) begin
            taken = (op == 4'd9) ? model_z : model_n;
            exp = expVec(0, 0, taken, !taken, 0, 3'b000, 0, 0);
        end else begin
            exp = expVec(0, 0, 0, 1, 0, 3'b000, 0, 0);
        end
        checkOutput({tag, "_arg"}, 0, exp);
        checkOutput({tag, "_arg"}, 1, exp);
        nextCycle();
        if (upd) begin
            model_z = fz;
            model_n = fn;
        end

        // Execute cycle for direct-mode ALU ops and STA
        if (exec) begin
            applyStimulus(8'($urandom), fz, fn);
            if (is_alu) begin
                exp = expVec(1, 0, 0, 0, 1, alu, 0, 0);
            end else begin
                exp = expVec(0, 0, 0, 0, 1, 3'b000, 1, 0);
            end
            checkOutput({tag, "_exec"}, 0, exp);
            checkOutput({tag, "_exec"}, 1, exp);
            nextCycle();
            if (is_alu) begin
                model_z = fz;
                model_n = fn;
            end
        end
    endtask

    // Hold reset for n cycles, checking that every output stays low
    task automatic resetFor(input string tag, input int n);
        rst_in = 1'b1;
        for (int i = 0; i < n; i++) begin
            applyStimulus(8'($urandom), 1'($urandom), 1'($urandom));
            checkOutput(tag, 0, 10'b0);
            checkOutput(tag, 1, 10'b0);
            nextCycle();
        end
        rst_in  = 1'b0;
        model_z = 0;
        model_n = 0;
    endtask

    // Safety net so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] opc;
        logic [9:0] exp;

        rst_in    = 1'b1;
        data_in   = 8'h00;
        flag_z_in = 1'b0;
        flag_n_in = 1'b0;
        model_z   = 0;
        model_n   = 0;
        @(negedge clk_in);

        resetFor("reset", 2);

        // Directed instructions
        executeInstr("lda_imm", 8'h10, 8'h00, 1'b1, 1'b0);
        executeInstr("bz_taken", 8'h90, 8'h05, 1'b0, 1'b0);
        executeInstr("add_dir", 8'h28, 8'h40, 1'b0, 1'b1);
        executeInstr("bz_not_taken", 8'h98, 8'h05, 1'b1, 1'b1);
        executeInstr("bn_taken", 8'hA0, 8'h07, 1'b0, 1'b0);
        executeInstr("sta_dir", 8'h78, 8'h80, 1'b1, 1'b1);
        executeInstr("sta_imm", 8'h70, 8'h80, 1'b1, 1'b1);
        executeInstr("sub_imm", 8'h37, 8'h01, 1'b0, 1'b0);
        executeInstr("bn_not_taken", 8'hA8, 8'h11, 1'b1, 1'b1);
        executeInstr("jmp", 8'h80, 8'h22, 1'b0, 1'b0);
        executeInstr("nop", 8'h00, 8'h33, 1'b1, 1'b1);
        executeInstr("reserved", 8'hB8, 8'h44, 1'b1, 1'b1);
        executeInstr("xor_dir", 8'h6F, 8'h55, 1'b1, 1'b0);

        // Reset in the middle of an instruction clears the flags too
        executeInstr("lda_z1", 8'h10, 8'h00, 1'b1, 1'b1);
        applyStimulus(8'h28, 1'b0, 1'b0);
        checkOutput("mid_fetch", 0, expVec(0, 0, 0, 1, 0, 3'b000, 0, 0));
        nextCycle();
        resetFor("mid_reset", 1);
        executeInstr("bz_after_reset", 8'h90, 8'h09, 1'b0, 1'b0);
        executeInstr("bn_after_reset", 8'hA0, 8'h09, 1'b0, 1'b0);

        // Randomized program (opcode F is covered separately)
        for (int i = 0; i < 200; i++) begin
            opc = {4'($urandom_range(0, 14)), 4'($urandom)};
            executeInstr("rand", opc, 8'($urandom), 1'($urandom), 1'($urandom));
        end

        // HLT: instance 0 halts, instance 1 runs it as a two-cycle NOP
        applyStimulus(8'hF0, 1'b0, 1'b0);
        exp = expVec(0, 0, 0, 1, 0, 3'b000, 0, 0);
        checkOutput("hlt_fetch", 0, exp);
        checkOutput("hlt_fetch", 1, exp);
        nextCycle();
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i == 1) ? 8'h00 : 8'($urandom), 1'($urandom), 1'($urandom));
            checkOutput("halted", 0, expVec(0, 0, 0, 0, 0, 3'b000, 0, 1));
            if (i < 2) begin
                checkOutput("hlt_as_nop", 1, expVec(0, 0, 0, 1, 0, 3'b000, 0, 0));
            end
            nextCycle();
        end
        resetFor("halt_reset", 1);
        executeInstr("after_halt", 8'h20, 8'h01, 1'b0, 1'b1);
        executeInstr("bn_after_halt", 8'hA0, 8'h02, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
